// File: rtl/matmul_ctrl_pkg.sv
// matmul_ctrl_pkg: shared types and constants for the matmul BRAM sequencer.
//   state_e      : controller FSM states
//   BRAM_RD_LAT  : BRAM read latency in cycles (enable -> doutb)
//   calc_num_*   : derive word counts from element dimensions
package matmul_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int BRAM_RD_LAT = 1;

  function automatic int calc_num_k(input int inner_dim, input int chunk);
    return inner_dim / chunk;
  endfunction

  function automatic int calc_num_w(input int w_outer_dim, input int chunk);
    return w_outer_dim / chunk;
  endfunction

  function automatic int calc_num_i(input int i_outer_dim, input int chunk);
    return i_outer_dim / chunk;
  endfunction

endpackage

// File: rtl/matmul_addr_gen.sv
// matmul_addr_gen: i/j/k loop counters and running base addresses.
//   clear    : zero all counters (takes priority)
//   step_k   : advance k, wrapping to 0 after the last k
//   step_j   : advance j (wrapping into i) and zero k
//   in_addr  = i*NUM_K + k,  wb_addr = j*NUM_K + k,  out_addr = i*NUM_W + j
//   k_zero / last_k / last_j / last_i : position flags for the FSM
// Bases are accumulated by NUM_K per step so no multipliers are needed.
module matmul_addr_gen
  import matmul_ctrl_pkg::*;
#(
  parameter int NUM_K      = 64,
  parameter int NUM_W      = 16,
  parameter int NUM_I      = 688,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  step_k,
  input  logic                  step_j,
  output logic [ADDR_WIDTH-1:0] in_addr,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  k_zero,
  output logic                  last_k,
  output logic                  last_j,
  output logic                  last_i
);

  localparam logic [ADDR_WIDTH-1:0] NK_A   = ADDR_WIDTH'(NUM_K);
  localparam logic [ADDR_WIDTH-1:0] LAST_K = ADDR_WIDTH'(NUM_K - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_J = ADDR_WIDTH'(NUM_W - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_I = ADDR_WIDTH'(NUM_I - 1);

  logic [ADDR_WIDTH-1:0] k_q, k_d, j_q, j_d, i_q, i_d;
  logic [ADDR_WIDTH-1:0] base_i_q, base_i_d, base_j_q, base_j_d;
  logic [ADDR_WIDTH-1:0] out_q, out_d;

  assign k_zero   = (k_q == '0);
  assign last_k   = (k_q == LAST_K);
  assign last_j   = (j_q == LAST_J);
  assign last_i   = (i_q == LAST_I);
  assign in_addr  = base_i_q + k_q;
  assign wb_addr  = base_j_q + k_q;
  assign out_addr = out_q;

  always_comb begin
    k_d      = k_q;
    j_d      = j_q;
    i_d      = i_q;
    base_i_d = base_i_q;
    base_j_d = base_j_q;
    out_d    = out_q;
    if (clear) begin
      k_d      = '0;
      j_d      = '0;
      i_d      = '0;
      base_i_d = '0;
      base_j_d = '0;
      out_d    = '0;
    end else begin
      if (step_k) k_d = last_k ? '0 : k_q + 1'b1;
      if (step_j) begin
        k_d   = '0;
        // out_addr walks i*NUM_W+j linearly, so it just counts writes
        out_d = last_j && last_i ? '0 : out_q + 1'b1;
        if (last_j) begin
          j_d      = '0;
          base_j_d = '0;
          i_d      = last_i ? '0 : i_q + 1'b1;
          base_i_d = last_i ? '0 : base_i_q + NK_A;
        end else begin
          j_d      = j_q + 1'b1;
          base_j_d = base_j_q + NK_A;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q      <= '0;
      j_q      <= '0;
      i_q      <= '0;
      base_i_q <= '0;
      base_j_q <= '0;
      out_q    <= '0;
    end else begin
      k_q      <= k_d;
      j_q      <= j_d;
      i_q      <= i_d;
      base_i_q <= base_i_d;
      base_j_q <= base_j_d;
      out_q    <= out_d;
    end
  end

endmodule

// File: rtl/matmul_bram_ctrl.sv
// matmul_bram_ctrl: sequences weight/input BRAM reads into the systolic
// matmul core and writes each finished output word to the output BRAM.
//   start/ready/done          : top-level handshake (start sampled in IDLE)
//   clr                       : synchronous abort to IDLE
//   wb_enb/wb_addrb, in_enb/in_addrb : BRAM read ports
//   core_ready/core_in_valid/core_first/core_last/core_out_valid : core i/f
//   out_we/out_addr           : output BRAM write port
// Optional: define MATMUL_CTRL_PERF_EN to add perf_cycles/perf_stalls.
module matmul_bram_ctrl
  import matmul_ctrl_pkg::*;
#(
  parameter int CHUNK_SIZE        = 4,
  parameter int INNER_DIMENSION   = 256,
  parameter int W_OUTER_DIMENSION = 64,
  parameter int I_OUTER_DIMENSION = 2752,
  parameter int ADDR_WIDTH        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  start,
  output logic                  ready,
  output logic                  done,
  output logic                  wb_enb,
  output logic [ADDR_WIDTH-1:0] wb_addrb,
  output logic                  in_enb,
  output logic [ADDR_WIDTH-1:0] in_addrb,
  input  logic                  core_ready,
  output logic                  core_in_valid,
  output logic                  core_first,
  output logic                  core_last,
  input  logic                  core_out_valid,
  output logic                  out_we,
  output logic [ADDR_WIDTH-1:0] out_addr
`ifdef MATMUL_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stalls
`endif
);

  localparam int NUM_K = calc_num_k(INNER_DIMENSION, CHUNK_SIZE);
  localparam int NUM_W = calc_num_w(W_OUTER_DIMENSION, CHUNK_SIZE);
  localparam int NUM_I = calc_num_i(I_OUTER_DIMENSION, CHUNK_SIZE);

  state_e state_q, state_d;
  logic   issue, ag_clear, step_j;
  logic   k_zero, last_k, last_j, last_i;

  // Per-stage {valid, first, last}; delays the issue flags to line up
  // with BRAM doutb.
  logic [BRAM_RD_LAT-1:0][2:0] rd_pipe_q, rd_pipe_d;

  assign issue    = (state_q == FETCH) && core_ready && !clr;
  assign ag_clear = clr || ((state_q == IDLE) && start);
  assign step_j   = (state_q == WRITE);

  matmul_addr_gen #(
    .NUM_K     (NUM_K),
    .NUM_W     (NUM_W),
    .NUM_I     (NUM_I),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (ag_clear),
    .step_k  (issue),
    .step_j  (step_j),
    .in_addr (in_addrb),
    .wb_addr (wb_addrb),
    .out_addr(out_addr),
    .k_zero  (k_zero),
    .last_k  (last_k),
    .last_j  (last_j),
    .last_i  (last_i)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (issue && last_k) state_d = WAIT;
      WAIT:    if (core_out_valid) state_d = WRITE;
      WRITE:   state_d = (last_i && last_j) ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_comb begin
    rd_pipe_d    = rd_pipe_q;
    rd_pipe_d[0] = {issue, issue & k_zero, issue & last_k};
    for (int s = 1; s < BRAM_RD_LAT; s++) rd_pipe_d[s] = rd_pipe_q[s-1];
  end

  assign ready         = (state_q == IDLE);
  assign done          = (state_q == DONE);
  assign out_we        = (state_q == WRITE);
  assign wb_enb        = issue;
  assign in_enb        = issue;
  assign core_in_valid = rd_pipe_q[BRAM_RD_LAT-1][2];
  assign core_first    = rd_pipe_q[BRAM_RD_LAT-1][1];
  assign core_last     = rd_pipe_q[BRAM_RD_LAT-1][0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_pipe_q <= rd_pipe_d;
    end
  end

`ifdef MATMUL_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d, perf_stalls_q, perf_stalls_d;

  // Counts run while out of IDLE, so they hold their last-run values once
  // DONE has returned to IDLE.
  always_comb begin
    perf_cycles_d = perf_cycles_q;
    perf_stalls_d = perf_stalls_q;
    if (state_q == IDLE) begin
      if (start && !clr) begin
        perf_cycles_d = '0;
        perf_stalls_d = '0;
      end
    end else begin
      perf_cycles_d = perf_cycles_q + 32'd1;
      if ((state_q == FETCH) && !core_ready) perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`else
  // Performance counters not built.
`endif

endmodule
